// File: rtl/tier2_ram_ctrl_if.sv
// Client-side handshake bundle for tier2_ram_ctrl: a write port that
// offers words and a read port that pulls the oldest stored word.
interface tier2_ram_ctrl_if #(
  parameter int WORD_WIDTH = 18
);
  logic                  wr_req;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic                  rd_ack;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Client side: raises requests, holds wr_data until wr_ack.
  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_ack, rd_data, rd_valid
  );

  // Controller side: grants requests and returns read data.
  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_ack, rd_data, rd_valid
  );
endinterface

// File: rtl/tier2_ram_ctrl.sv
// Circular FIFO controller in front of a single-port RAM with registered
// read data. At most one RAM access per cycle; contested cycles are
// arbitrated round-robin between the write and read sides. DEPTH must not
// exceed 2**ADDR_WIDTH; pointers wrap at DEPTH, not at the address range.
module tier2_ram_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 18,
  parameter int DEPTH      = 12288
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  tier2_ram_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] laddr_wr,
  output logic [ADDR_WIDTH-1:0] laddr_rd,
  output logic [WORD_WIDTH-1:0] output_to_ram,
  output logic                  lram_write_en,
  output logic                  lram_read_en,
  input  logic [WORD_WIDTH-1:0] ldata_ram,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  rd_valid_reg;
  grant_t                last_grant_reg;

  logic full_int;
  logic empty_int;
  logic wr_elig;
  logic rd_elig;
  logic wr_grant;
  logic rd_grant;

  assign full_int  = (count_reg == DEPTH_CNT);
  assign empty_int = (count_reg == '0);

  // Eligibility is gated by rst so that no grant can escape while the
  // block is held in reset, even though the requests may still be high.
  assign wr_elig = rst & bus.wr_req & ~full_int  & ~flush;
  assign rd_elig = rst & bus.rd_req & ~empty_int & ~flush;

  // Round-robin: an uncontested request always wins; when both are
  // eligible, the side that did not win last time goes.
  assign wr_grant = wr_elig & (~rd_elig | (last_grant_reg == GRANT_RD));
  assign rd_grant = rd_elig & (~wr_elig | (last_grant_reg == GRANT_WR));

  assign wr_ptr_next = (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + ADDR_ONE;
  assign rd_ptr_next = (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + ADDR_ONE;

  // Buffer bookkeeping: pointers, occupancy and arbitration history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= GRANT_RD;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= GRANT_RD;
    end else begin
      if (wr_grant) begin
        wr_ptr_reg <= wr_ptr_next;
      end
      if (rd_grant) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      // Grants are mutually exclusive, so at most one of these fires;
      // full/empty gating keeps count inside 0..DEPTH.
      if (wr_grant) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (rd_grant) begin
        count_reg <= count_reg - CNT_ONE;
      end
      if (wr_grant) begin
        last_grant_reg <= GRANT_WR;
      end else if (rd_grant) begin
        last_grant_reg <= GRANT_RD;
      end
    end
  end

  // Read data arrives from the RAM one cycle after the address; flag it.
  // A read acked just before a flush still reports its word, because the
  // ack itself was registered on the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_grant;
    end
  end

  assign bus.wr_ack   = wr_grant;
  assign bus.rd_ack   = rd_grant;
  assign bus.rd_data  = ldata_ram;
  assign bus.rd_valid = rd_valid_reg;

  assign laddr_wr      = wr_ptr_reg;
  assign laddr_rd      = rd_ptr_reg;
  assign output_to_ram = bus.wr_data;
  assign lram_write_en = wr_grant;
  assign lram_read_en  = rd_grant;

  assign count = count_reg;
  assign full  = full_int;
  assign empty = empty_int;

endmodule

// File: tb/tb_tier2_ram_ctrl.sv
// Bench for tier2_ram_ctrl: a synchronous single-port RAM model sits on
// the RAM side, and a queue-based FIFO model predicts every grant, flag,
// address and returned word.
module tb_tier2_ram_ctrl;
  localparam int AW    = 14;
  localparam int WW    = 18;
  localparam int DEPTH = 12288;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  tier2_ram_ctrl_if #(.WORD_WIDTH(WW)) bus ();

  logic [AW-1:0] laddr_wr, laddr_rd;
  logic [WW-1:0] output_to_ram;
  logic [WW-1:0] ldata_ram;
  logic          lram_write_en, lram_read_en;
  logic [AW:0]   count;
  logic          full, empty;

  tier2_ram_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus.slave),
    .laddr_wr      (laddr_wr),
    .laddr_rd      (laddr_rd),
    .output_to_ram (output_to_ram),
    .lram_write_en (lram_write_en),
    .lram_read_en  (lram_read_en),
    .ldata_ram     (ldata_ram),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  // Single-port RAM with registered read.
  logic [WW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (lram_write_en) ram[laddr_wr] <= output_to_ram;
    if (lram_read_en)  ldata_ram <= ram[laddr_rd];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored words in arrival order, write/read counts
  // modulo DEPTH, and which side won the last grant.
  logic [WW-1:0] mq[$];
  int            m_wptr = 0;
  int            m_rptr = 0;
  bit            m_last_wr = 1'b0;
  bit            m_rv = 1'b0;
  logic [WW-1:0] m_rdata = '0;

  // Expectations for the cycle currently being sampled.
  bit            e_wack, e_rack, e_full, e_empty, e_rv;
  logic [AW:0]   e_count;
  logic [AW-1:0] e_wa, e_ra;
  logic [WW-1:0] e_rdata;

  // Apply one cycle of stimulus, sample point is negedge+1, then advance
  // the model to what the next edge should produce.
  task automatic drive(input bit w, input logic [WW-1:0] d, input bit r, input bit f);
    bit we, re;
    @(negedge clk);
    bus.wr_req = w; bus.wr_data = d; bus.rd_req = r; flush = f;
    #1;
    we = w && (mq.size() < DEPTH) && !f;
    re = r && (mq.size() > 0) && !f;
    e_wack  = we && (!re || !m_last_wr);
    e_rack  = re && (!we || m_last_wr);
    e_count = (AW+1)'(mq.size());
    e_full  = (mq.size() == DEPTH);
    e_empty = (mq.size() == 0);
    e_wa    = AW'(m_wptr);
    e_ra    = AW'(m_rptr);
    e_rv    = m_rv;
    e_rdata = m_rdata;
    m_rv = e_rack;
    if (e_rack) begin m_rdata = mq.pop_front(); m_rptr = (m_rptr + 1) % DEPTH; end
    if (e_wack) begin mq.push_back(d); m_wptr = (m_wptr + 1) % DEPTH; end
    if (e_wack || e_rack) m_last_wr = e_wack;
    if (f) begin mq.delete(); m_wptr = 0; m_rptr = 0; m_last_wr = 1'b0; end
  endtask

  task automatic test_reset;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_data = '1; flush = 1'b0;
    #3;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (bus.wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_wr_ack: got %b want 0", bus.wr_ack); end
    n_vec++; if (bus.rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack: got %b want 0", bus.rd_ack); end
    @(posedge clk); #1;
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_vec++; if (laddr_wr !== '0 || laddr_rd !== '0) begin n_err++; $display("FAIL reset_addr: got wr=%0d rd=%0d want 0/0", laddr_wr, laddr_rd); end
    @(negedge clk);
    rst = 1'b1; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_write_read;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, WW'(i), 1'b0, 1'b0);
      n_vec++; if (bus.wr_ack !== 1'b1 || laddr_wr !== AW'(i-1)) begin n_err++; $display("FAIL wr_seq_%0d: got ack=%b addr=%0d want 1/%0d", i, bus.wr_ack, laddr_wr, i-1); end
    end
    for (int i = 0; i <= 5; i++) begin
      drive(1'b0, '0, (i < 5), 1'b0);
      n_vec++; if (bus.rd_ack !== (i < 5)) begin n_err++; $display("FAIL rd_seq_ack_%0d: got %b want %b", i, bus.rd_ack, (i < 5)); end
      n_vec++; if (bus.rd_valid !== (i > 0)) begin n_err++; $display("FAIL rd_seq_valid_%0d: got %b want %b", i, bus.rd_valid, (i > 0)); end
      if (i > 0) begin
        n_vec++; if (bus.rd_data !== WW'(i)) begin n_err++; $display("FAIL rd_seq_data_%0d: got %0h want %0h", i, bus.rd_data, i); end
      end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rd_seq_empty: got %b want 1", empty); end
    $display("test_write_read done");
  endtask

  task automatic test_back_to_back;
    logic [WW-1:0] d;
    for (int i = 0; i < 4; i++) drive(1'b1, WW'($urandom), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    d = WW'($urandom);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, d, 1'b1, 1'b0);
      n_vec++; if (bus.wr_ack !== (k % 2 == 0) || bus.rd_ack !== (k % 2 == 1)) begin n_err++; $display("FAIL alt_grant_%0d: got w=%b r=%b want w=%b r=%b", k, bus.wr_ack, bus.rd_ack, (k % 2 == 0), (k % 2 == 1)); end
      n_vec++; if (count !== (AW+1)'(3 + k % 2)) begin n_err++; $display("FAIL alt_count_%0d: got %0d want %0d", k, count, 3 + k % 2); end
      if (e_rv) begin
        n_vec++; if (bus.rd_data !== e_rdata) begin n_err++; $display("FAIL alt_data_%0d: got %0h want %0h", k, bus.rd_data, e_rdata); end
      end
      if (e_wack) d = WW'($urandom);
    end
    while (mq.size() > 0 || m_rv) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (bus.rd_valid !== e_rv || (e_rv && bus.rd_data !== e_rdata)) begin n_err++; $display("FAIL alt_drain: got v=%b d=%0h want v=%b d=%0h", bus.rd_valid, bus.rd_data, e_rv, e_rdata); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_full_wrap;
    logic [WW-1:0] d;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WW'($urandom), 1'b0, 1'b0);
      n_vec++; if (bus.wr_ack !== 1'b1 || laddr_wr !== AW'(i)) begin n_err++; $display("FAIL fill_%0d: got ack=%b addr=%0d want 1/%0d", i, bus.wr_ack, laddr_wr, i); end
    end
    d = WW'($urandom);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, d, 1'b0, 1'b0);
      n_vec++; if (bus.wr_ack !== 1'b0 || full !== 1'b1) begin n_err++; $display("FAIL full_block_%0d: got ack=%b full=%b want 0/1", i, bus.wr_ack, full); end
      n_vec++; if (count !== (AW+1)'(DEPTH) || laddr_wr !== '0) begin n_err++; $display("FAIL full_state_%0d: got count=%0d addr=%0d want %0d/0", i, count, laddr_wr, DEPTH); end
    end
    drive(1'b1, d, 1'b1, 1'b0);
    n_vec++; if (bus.rd_ack !== 1'b1 || bus.wr_ack !== 1'b0) begin n_err++; $display("FAIL full_read: got r=%b w=%b want 1/0", bus.rd_ack, bus.wr_ack); end
    drive(1'b1, d, 1'b0, 1'b0);
    n_vec++; if (bus.wr_ack !== 1'b1 || laddr_wr !== '0 || full !== 1'b0) begin n_err++; $display("FAIL wrap_write: got ack=%b addr=%0d full=%b want 1/0/0", bus.wr_ack, laddr_wr, full); end
    n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== e_rdata) begin n_err++; $display("FAIL wrap_first_read: got v=%b d=%0h want 1/%0h", bus.rd_valid, bus.rd_data, e_rdata); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (bus.rd_ack !== 1'b1 || laddr_rd !== e_ra) begin n_err++; $display("FAIL drain_ack_%0d: got ack=%b addr=%0d want 1/%0d", i, bus.rd_ack, laddr_rd, e_ra); end
      if (e_rv) begin
        n_vec++; if (bus.rd_data !== e_rdata) begin n_err++; $display("FAIL drain_data_%0d: got %0h want %0h", i, bus.rd_data, e_rdata); end
      end
    end
    $display("test_full_wrap done");
  endtask

  task automatic test_empty_read;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (bus.rd_valid !== e_rv || (e_rv && bus.rd_data !== e_rdata)) begin n_err++; $display("FAIL empty_last: got v=%b d=%0h want v=%b d=%0h", bus.rd_valid, bus.rd_data, e_rv, e_rdata); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (bus.rd_ack !== 1'b0 || bus.rd_valid !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL empty_read_%0d: got ack=%b v=%b empty=%b want 0/0/1", i, bus.rd_ack, bus.rd_valid, empty); end
    end
    $display("test_empty_read done");
  endtask

  task automatic test_flush;
    logic [WW-1:0] d;
    for (int i = 0; i < 101; i++) drive(1'b1, WW'($urandom), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, WW'($urandom), 1'b1, 1'b1);
    n_vec++; if (count !== (AW+1)'(100)) begin n_err++; $display("FAIL flush_pre_count: got %0d want 100", count); end
    n_vec++; if (bus.wr_ack !== 1'b0 || bus.rd_ack !== 1'b0) begin n_err++; $display("FAIL flush_no_grant: got w=%b r=%b want 0/0", bus.wr_ack, bus.rd_ack); end
    n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== e_rdata) begin n_err++; $display("FAIL flush_pending_valid: got v=%b d=%0h want 1/%0h", bus.rd_valid, bus.rd_data, e_rdata); end
    d = WW'($urandom);
    drive(1'b1, d, 1'b0, 1'b0);
    n_vec++; if (count !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_clear: got count=%0d empty=%b want 0/1", count, empty); end
    n_vec++; if (bus.wr_ack !== 1'b1 || laddr_wr !== '0 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL flush_next_write: got ack=%b addr=%0d v=%b want 1/0/0", bus.wr_ack, laddr_wr, bus.rd_valid); end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_vec++; if (bus.rd_ack !== 1'b1 || laddr_rd !== '0) begin n_err++; $display("FAIL flush_read_addr: got ack=%b addr=%0d want 1/0", bus.rd_ack, laddr_rd); end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d) begin n_err++; $display("FAIL flush_readback: got v=%b d=%0h want 1/%0h", bus.rd_valid, bus.rd_data, d); end
    $display("test_flush done");
  endtask

  task automatic test_random;
    logic [WW-1:0] d;
    bit w, r, f;
    int wp;
    d = WW'($urandom);
    for (int i = 0; i < 3000; i++) begin
      wp = (i / 500) % 2 == 0 ? 70 : 30;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 199) == 0);
      drive(w, d, r, f);
      n_vec++; if (bus.wr_ack !== e_wack || bus.rd_ack !== e_rack) begin n_err++; $display("FAIL rnd_grant_%0d: got w=%b r=%b want w=%b r=%b", i, bus.wr_ack, bus.rd_ack, e_wack, e_rack); end
      n_vec++; if (count !== e_count || full !== e_full || empty !== e_empty) begin n_err++; $display("FAIL rnd_level_%0d: got c=%0d f=%b e=%b want c=%0d f=%b e=%b", i, count, full, empty, e_count, e_full, e_empty); end
      n_vec++; if (laddr_wr !== e_wa || laddr_rd !== e_ra) begin n_err++; $display("FAIL rnd_addr_%0d: got wa=%0d ra=%0d want wa=%0d ra=%0d", i, laddr_wr, laddr_rd, e_wa, e_ra); end
      n_vec++; if (lram_write_en !== e_wack || lram_read_en !== e_rack || output_to_ram !== d) begin n_err++; $display("FAIL rnd_ram_port_%0d: got we=%b re=%b wd=%0h want we=%b re=%b wd=%0h", i, lram_write_en, lram_read_en, output_to_ram, e_wack, e_rack, d); end
      n_vec++; if (bus.rd_valid !== e_rv) begin n_err++; $display("FAIL rnd_valid_%0d: got %b want %b", i, bus.rd_valid, e_rv); end
      if (e_rv) begin
        n_vec++; if (bus.rd_data !== e_rdata) begin n_err++; $display("FAIL rnd_data_%0d: got %0h want %0h", i, bus.rd_data, e_rdata); end
      end
      if (e_wack) d = WW'($urandom);
    end
    $display("test_random done");
  endtask

  task automatic test_reset_midstream;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, WW'($urandom), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    n_vec++; if (count !== (AW+1)'(7) || bus.rd_ack !== 1'b1) begin n_err++; $display("FAIL mid_pre: got count=%0d ack=%b want 7/1", count, bus.rd_ack); end
    #1 rst = 1'b0; bus.wr_req = 1'b1;
    #1;
    n_vec++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL mid_rst_level: got c=%0d e=%b f=%b want 0/1/0", count, empty, full); end
    n_vec++; if (bus.wr_ack !== 1'b0 || bus.rd_ack !== 1'b0 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_hs: got w=%b r=%b v=%b want 0/0/0", bus.wr_ack, bus.rd_ack, bus.rd_valid); end
    n_vec++; if (laddr_wr !== '0 || laddr_rd !== '0) begin n_err++; $display("FAIL mid_rst_addr: got wa=%0d ra=%0d want 0/0", laddr_wr, laddr_rd); end
    @(posedge clk); #1;
    n_vec++; if (bus.rd_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL mid_rst_hold: got v=%b c=%0d want 0/0", bus.rd_valid, count); end
    @(negedge clk);
    rst = 1'b1; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    mq.delete(); m_wptr = 0; m_rptr = 0; m_last_wr = 1'b0; m_rv = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (bus.rd_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL mid_post: got v=%b c=%0d want 0/0", bus.rd_valid, count); end
    drive(1'b1, WW'($urandom), 1'b1, 1'b0);
    n_vec++; if (bus.wr_ack !== 1'b1 || bus.rd_ack !== 1'b0 || laddr_wr !== '0) begin n_err++; $display("FAIL mid_first_write: got w=%b r=%b addr=%0d want 1/0/0", bus.wr_ack, bus.rd_ack, laddr_wr); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = '0;
    test_reset;
    test_write_read;
    test_back_to_back;
    test_full_wrap;
    test_empty_read;
    test_flush;
    test_random;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
